line_engine_param: RTL
======================

# line_engine_param

Parametrised Bresenham line engine for the frame-buffer write path. It takes colour and endpoints from the processor-side register interface, rasterises the line, and writes pixels to the DDR address FIFO and write-data FIFO as two-beat, 8-pixel bursts. Unlike the first-generation engine, it has a parameterised coordinate width and frame-select field. It can also coalesce every pixel that falls in the same 8-pixel block into one masked burst, which cuts memory traffic on shallow lines.

## Interface
- COORD_W, 10: bits per coordinate (x and y).
- ADDR_W, 31: af_addr_din width. Requires ADDR_W ≥ 6 + 2·COORD_W − 1.
- FRAME_LSB, 22: frame select is frame_base[FRAME_LSB+5:FRAME_LSB].
- COALESCE, 1: 1 merges same-block pixels into one burst; 0 issues one burst per pixel (legacy behaviour).
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- ready  out  1  high in IDLE only.
- color  in  32  pixel colour; only [23:0] is used.
- point  in  2·COORD_W  {x, y}, with x in the upper half.
- color_valid, point0_valid, point1_valid  in  1  each latches its register when ready is high.
- trigger  in  1  starts drawing when ready is high.
- frame_base  in  32  frame buffer base address.
- af_full, wdf_full  in  1  FIFO full flags.
- af_addr_din  out  ADDR_W  burst address.
- af_wr_en  out  1  address write enable.
- wdf_din  out  128  write data, {4{8'h00, color[23:0]}}.
- wdf_mask_din  out  16  byte mask; 1 = byte not written.
- wdf_wr_en  out  1  data write enable.
- done  out  1  one-cycle pulse when the last burst completes.

## Operation
- States: IDLE → SETUP → STEP ⇄ WRITE0 → WRITE1 → STEP or IDLE.
- **Register capture.** Valid strobes update their registers in any ready cycle.
  - A strobe in the same cycle as trigger is captured, and SETUP uses the new value.
  - Strobes are ignored outside IDLE.
- **SETUP (one cycle).**
  - steep = |y1−y0| > |x1−x0|. If steep, swap x and y of both endpoints.
  - Then, if x0 > x1, swap the endpoints.
  - dx = x1−x0 (≥ 0), dy = |y1−y0|, ystep = +1 if y0 < y1, else −1.
  - err = dx>>1.
  - All arithmetic is signed, COORD_W+2 bits.
- **Plot coordinates.**
  - Screen (sx, sy) = (y, x) if steep, else (x, y).
  - Block key = {sy, sx[COORD_W-1:3]}. Pixel index p = sx[2:0].
- **STEP (one cycle per pixel).**
  - OR bit p into an 8-bit enable vector.
  - Update the Bresenham state: err −= dy; if err < 0 then y += ystep and err += dx. Then x += 1.
  - Go to WRITE0 if the pixel just plotted was the last (x == x1), or if COALESCE=0, or if the next pixel's block key differs. Otherwise stay in STEP.
- **Burst address.** af_addr_din = {zero pad, frame_base[FRAME_LSB+5:FRAME_LSB], sy, sx[COORD_W-1:3], 2'b00}, using the key of the accumulated block.
- **Byte masks.**
  - Beat 0 covers p = 0..3; beat 1 covers p = 4..7.
  - Pixel p within its beat (q = p mod 4) clears bytes [15−4q : 12−4q]. All other bytes are 1.
- **WRITE0.** When !af_full && !wdf_full, assert af_wr_en and wdf_wr_en together with the beat-0 mask, then go to WRITE1. Otherwise hold with both enables low.
- **WRITE1.** When !wdf_full, assert wdf_wr_en with the beat-1 mask. af_wr_en stays low and the enable vector is cleared. Then:
  - if the line is finished, go to IDLE and pulse done next cycle;
  - else go to STEP.
- **Degenerate lines.**
  - Equal endpoints produce exactly one pixel and one burst.
  - There is no clipping: out-of-range coordinates wrap in their address fields.

## Timing
- **Reset values.** All outputs are 0 except ready = 1 and wdf_mask_din = 16'hFFFF. The enable vector is 0 and the state is IDLE.
- **Reset mid-line.** The line aborts next edge. A half-written burst is discarded downstream by the same rst.
- **Enables.** af_wr_en and wdf_wr_en are combinational from state and the full flags, and are never asserted while the relevant FIFO is full.
- **Start latency.** Trigger accepted in cycle T: SETUP at T+1, first STEP at T+2.
- **Burst length.** Each burst takes n STEP cycles (n = pixels in the block), plus WRITE0 and WRITE1, plus any stall cycles.
- **Completion.** done and ready rise in the cycle after the final WRITE1 is accepted. A new trigger is accepted in that same cycle.
- **Data stability.** wdf_din is stable from SETUP until IDLE.

## Test plan
- **Horizontal, aligned.**
  - Stimulus: frame_base = 0x00400000, color = 0x00AABBCC, line (0,5)→(7,5), COALESCE=1.
  - Required: one burst at af_addr_din = 0x80A00, masks 16'h0000 then 16'h0000, done at T+12, wdf_din = {4{32'h00AABBCC}}.
- **Same line, COALESCE=0.** 8 bursts, all at addr 0x80A00. Beat-0 masks 0FFF, F0FF, FF0F, FFF0 (beat 1 = FFFF); then beat-1 masks 0FFF through FFF0 (beat 0 = FFFF).
- **Reversed endpoints and steep line.**
  - Line (7,5)→(0,5) gives results identical to the horizontal, aligned case.
  - Line (3,0)→(3,3) gives 4 bursts, with y = 0..3 at addresses 0x80000 + 0x200·y, beat-0 mask FFF0 and beat-1 mask FFFF.
- **Diagonal (0,0)→(3,3).** 4 bursts at y = 0..3, beat-0 masks 0FFF, F0FF, FF0F, FFF0.
- **Single point (4,2)→(4,2).** One burst: beat-0 mask FFFF, beat-1 mask 0FFF.
- **Backpressure and reset.**
  - Hold af_full high for 5 cycles in WRITE0: no enables, state held, then the burst completes unchanged.
  - Hold wdf_full in WRITE1: beat 1 is delayed.
  - Assert rst in STEP: next cycle all outputs are at reset values and ready = 1.

Source files
------------

// File: rtl/line_engine_param_if.sv
// Host and DDR-FIFO signal bundle for line_engine_param.
// master = the engine, slave = register block and FIFOs.
interface line_engine_param_if #(
  parameter int COORD_W = 10,
  parameter int ADDR_W  = 31
);
  logic                   ready;
  logic [31:0]            color;
  logic [2*COORD_W-1:0]   point;
  logic                   color_valid;
  logic                   point0_valid;
  logic                   point1_valid;
  logic                   trigger;
  logic [31:0]            frame_base;
  logic                   af_full;
  logic                   wdf_full;
  logic [ADDR_W-1:0]      af_addr_din;
  logic                   af_wr_en;
  logic [127:0]           wdf_din;
  logic [15:0]            wdf_mask_din;
  logic                   wdf_wr_en;
  logic                   done;

  modport master (
    input  color, point, color_valid, point0_valid, point1_valid,
    input  trigger, frame_base, af_full, wdf_full,
    output ready, af_addr_din, af_wr_en, wdf_din, wdf_mask_din,
    output wdf_wr_en, done
  );

  modport slave (
    output color, point, color_valid, point0_valid, point1_valid,
    output trigger, frame_base, af_full, wdf_full,
    input  ready, af_addr_din, af_wr_en, wdf_din, wdf_mask_din,
    input  wdf_wr_en, done
  );
endinterface

// File: rtl/line_engine_param.sv
// Bresenham line rasteriser writing 8-pixel masked bursts
// to the DDR address and write-data FIFOs.
module line_engine_param #(
  parameter int COORD_W   = 10,
  parameter int ADDR_W    = 31,
  parameter int FRAME_LSB = 22,
  parameter bit COALESCE  = 1'b1
) (
  input logic clk,
  input logic rst,
  line_engine_param_if.master bus
);
  localparam int W  = COORD_W + 2;
  localparam int KW = 2 * COORD_W - 3;

  typedef enum logic [2:0] {
    IDLE, SETUP, STEP, WRITE0, WRITE1
  } state_t;

  state_t state, state_n;

  logic [23:0]          col;
  logic [2*COORD_W-1:0] p0, p1;
  logic signed [W-1:0]  x, y, x1, dx, dy, err;
  logic                 steep, yneg, fin, done_q;
  logic [7:0]           en;
  logic [KW-1:0]        key;

  logic signed [W-1:0] ax0, ay0, ax1, ay1, adx, ady;
  logic signed [W-1:0] cx0, cy0, cx1, cy1;
  logic signed [W-1:0] bx0, by0, bx1, by1;
  logic signed [W-1:0] s_dx, s_dy;
  logic                s_steep, s_yneg;

  always_comb begin
    ax0 = $signed({2'b00, p0[2*COORD_W-1:COORD_W]});
    ay0 = $signed({2'b00, p0[COORD_W-1:0]});
    ax1 = $signed({2'b00, p1[2*COORD_W-1:COORD_W]});
    ay1 = $signed({2'b00, p1[COORD_W-1:0]});
    adx = (ax1 >= ax0) ? ax1 - ax0 : ax0 - ax1;
    ady = (ay1 >= ay0) ? ay1 - ay0 : ay0 - ay1;
    s_steep = ady > adx;
    cx0 = s_steep ? ay0 : ax0;
    cy0 = s_steep ? ax0 : ay0;
    cx1 = s_steep ? ay1 : ax1;
    cy1 = s_steep ? ax1 : ay1;
    bx0 = cx0;
    by0 = cy0;
    bx1 = cx1;
    by1 = cy1;
    if (cx0 > cx1) begin
      bx0 = cx1;
      by0 = cy1;
      bx1 = cx0;
      by1 = cy0;
    end
    s_dx   = bx1 - bx0;
    s_dy   = (by1 >= by0) ? by1 - by0 : by0 - by1;
    s_yneg = !(by0 < by1);
  end

  logic signed [W-1:0] sx, sy, nsx, nsy, e2, nx, ny, ne;
  logic [KW-1:0]       cur_key, nxt_key;
  logic [2:0]          pix;
  logic                last;

  always_comb begin
    sx      = steep ? y : x;
    sy      = steep ? x : y;
    cur_key = {sy[COORD_W-1:0], sx[COORD_W-1:3]};
    pix     = sx[2:0];
    e2      = err - dy;
    nx      = x + W'(1);
    ny      = y;
    ne      = e2;
    if (e2[W-1]) begin
      ny = yneg ? y - W'(1) : y + W'(1);
      ne = e2 + dx;
    end
    nsx     = steep ? ny : nx;
    nsy     = steep ? nx : ny;
    nxt_key = {nsy[COORD_W-1:0], nsx[COORD_W-1:3]};
    last    = (x == x1);
  end

  always_comb begin
    state_n       = state;
    bus.af_wr_en  = 1'b0;
    bus.wdf_wr_en = 1'b0;
    case (state)
      IDLE:   if (bus.trigger) state_n = SETUP;
      SETUP:  state_n = STEP;
      STEP: begin
        if (last || !COALESCE || nxt_key != cur_key)
          state_n = WRITE0;
      end
      WRITE0: begin
        if (!bus.af_full && !bus.wdf_full) begin
          bus.af_wr_en  = 1'b1;
          bus.wdf_wr_en = 1'b1;
          state_n       = WRITE1;
        end
      end
      WRITE1: begin
        if (!bus.wdf_full) begin
          bus.wdf_wr_en = 1'b1;
          state_n       = fin ? IDLE : STEP;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      col    <= '0;
      p0     <= '0;
      p1     <= '0;
      x      <= '0;
      y      <= '0;
      x1     <= '0;
      dx     <= '0;
      dy     <= '0;
      err    <= '0;
      steep  <= 1'b0;
      yneg   <= 1'b0;
      fin    <= 1'b0;
      en     <= '0;
      key    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= (state == WRITE1) && !bus.wdf_full && fin;
      case (state)
        IDLE: begin
          if (bus.color_valid)  col <= bus.color[23:0];
          if (bus.point0_valid) p0  <= bus.point;
          if (bus.point1_valid) p1  <= bus.point;
        end
        SETUP: begin
          x     <= bx0;
          y     <= by0;
          x1    <= bx1;
          dx    <= s_dx;
          dy    <= s_dy;
          err   <= s_dx >>> 1;
          steep <= s_steep;
          yneg  <= s_yneg;
          en    <= '0;
        end
        STEP: begin
          en  <= en | (8'b1 << pix);
          key <= cur_key;
          x   <= nx;
          y   <= ny;
          err <= ne;
          fin <= last;
        end
        WRITE1: if (!bus.wdf_full) en <= '0;
        default: ;
      endcase
    end
  end

  function automatic logic [15:0] beat_mask(input logic [3:0] e);
    beat_mask = 16'hFFFF;
    for (int q = 0; q < 4; q++)
      if (e[q]) beat_mask[15-4*q -: 4] = 4'h0;
  endfunction

  logic busy_wr;
  assign busy_wr = (state == WRITE0) || (state == WRITE1);

  always_comb begin
    bus.af_addr_din  = '0;
    bus.wdf_mask_din = 16'hFFFF;
    if (busy_wr)
      bus.af_addr_din = ADDR_W'({bus.frame_base[FRAME_LSB+5:FRAME_LSB],
                                 key, 2'b00});
    if (state == WRITE0) bus.wdf_mask_din = beat_mask(en[3:0]);
    if (state == WRITE1) bus.wdf_mask_din = beat_mask(en[7:4]);
  end

  assign bus.ready   = (state == IDLE);
  assign bus.done    = done_q;
  assign bus.wdf_din = {4{8'h00, col}};

  logic unused;
  assign unused = ^{bus.color[31:24], bus.frame_base,
                    sx, sy, nsx, nsy};
endmodule
